// File: rtl/ob_pkg.sv
// Shared order-book types: table entries, reject responses and egress sizing.
package ob_pkg;

    localparam int unsigned ID_W    = 8;
    localparam int unsigned PRICE_W = 16;
    localparam int unsigned QTY_W   = 16;

    typedef struct packed {
        logic [ID_W-1:0]    order_id;
        logic [PRICE_W-1:0] price;
        logic [QTY_W-1:0]   qty;
    } table_t;

    typedef struct packed {
        logic   is_ask;
        table_t entry;
    } reject_rsp_t;

    localparam int REJECT_FIFO_D = 4;

endpackage

// File: rtl/ob_fifo.sv
// Generic synchronous FIFO with registered full/empty flags, shared by the order-book egress paths.
module ob_fifo #(
    parameter int unsigned W = 8,
    parameter int unsigned D = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [W-1:0]         push_data,
    input  logic                 pop,
    output logic [W-1:0]         pop_data,
    output logic                 full,
    output logic                 empty,
    output logic [$clog2(D):0]   count
);

    localparam int unsigned AW = $clog2(D);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [D];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic          full_q;
    logic          empty_q;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_pop    = pop & ~empty_q;
    assign do_push   = push & (~full_q | do_pop);
    assign count_nxt = count_q + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(D); i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_nxt;
            full_q  <= (count_nxt == CW'(D));
            empty_q <= (count_nxt == '0);
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;

endmodule

// File: rtl/ob_reject_drain.sv
// Drains bid/ask table reject slots round-robin into a response FIFO and keeps
// saturating per-side reject counters.
module ob_reject_drain
    import ob_pkg::*;
#(
    parameter int unsigned D     = REJECT_FIFO_D,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bid_reject_valid_r,
    input  table_t           bid_reject_r,
    output logic             bid_reject_pop,
    input  logic             ask_reject_valid_r,
    input  table_t           ask_reject_r,
    output logic             ask_reject_pop,
    output logic             rsp_vld_r,
    output reject_rsp_t      rsp_r,
    input  logic             rsp_accept,
    output logic [CNT_W-1:0] bid_cnt_r,
    output logic [CNT_W-1:0] ask_cnt_r
);

    localparam int unsigned CW = $clog2(D) + 1;
    localparam int unsigned RW = $bits(reject_rsp_t);

    logic          bid_mask;
    logic          ask_mask;
    logic          prefer_ask;
    logic          rsp_fire;
    logic          space;
    logic          bid_elig;
    logic          ask_elig;
    logic          grant_ask;
    logic          push;
    reject_rsp_t   push_data;
    logic [RW-1:0] head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          unused_count;

    assign rsp_fire = rsp_vld_r & rsp_accept;
    assign space    = ~fifo_full | rsp_fire;

    // Masks hide the table's stale valid in the cycle after a pop; reset kills pops at once.
    assign bid_elig  = bid_reject_valid_r & ~bid_mask & space & ~rst;
    assign ask_elig  = ask_reject_valid_r & ~ask_mask & space & ~rst;
    assign grant_ask = ask_elig & (~bid_elig | prefer_ask);

    assign bid_reject_pop = bid_elig & ~grant_ask;
    assign ask_reject_pop = grant_ask;
    assign push           = bid_reject_pop | ask_reject_pop;

    assign push_data.is_ask = grant_ask;
    assign push_data.entry  = grant_ask ? ask_reject_r : bid_reject_r;

    ob_fifo #(
        .W (RW),
        .D (D)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (rsp_fire),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rsp_vld_r    = ~fifo_empty;
    assign rsp_r        = reject_rsp_t'(head);
    assign unused_count = ^fifo_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bid_mask   <= 1'b0;
            ask_mask   <= 1'b0;
            prefer_ask <= 1'b0;
            bid_cnt_r  <= '0;
            ask_cnt_r  <= '0;
        end else begin
            bid_mask <= bid_reject_pop;
            ask_mask <= ask_reject_pop;
            if (bid_reject_pop) begin
                prefer_ask <= 1'b1;
            end else if (ask_reject_pop) begin
                prefer_ask <= 1'b0;
            end
            if (bid_reject_pop && (bid_cnt_r != '1)) begin
                bid_cnt_r <= bid_cnt_r + CNT_W'(1);
            end
            if (ask_reject_pop && (ask_cnt_r != '1)) begin
                ask_cnt_r <= ask_cnt_r + CNT_W'(1);
            end
        end
    end

endmodule
